node_config_loader: RTL and testbench
=====================================

NODE_CONFIG_LOADER -- requirements
Module: node_config_loader

Interface
REQ-001 Parameter NUM_NODES, default 31, number of internal nodes in the tree (depth-5 tree).
REQ-002 Parameter STORAGE_WIDTH, default 22, node record width: [21:11] median, [10:0] index, with only [2:0] significant in the index field.
REQ-003 Parameter ADDR_WIDTH, default 5, counter width; SHALL satisfy 2^ADDR_WIDTH >= NUM_NODES.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 start  input  1  one-cycle pulse that begins a configuration load.
REQ-007 abort  input  1  terminates a load in progress.
REQ-008 in_valid  input  1  node record available.
REQ-009 in_ready  output  1  loader accepts a record.
REQ-010 in_data  input  STORAGE_WIDTH  node record.
REQ-011 wen  output  NUM_NODES  one-hot per-node write enable.
REQ-012 wdata  output  STORAGE_WIDTH  record broadcast to all nodes.
REQ-013 busy  output  1  high in LOAD.
REQ-014 done  output  1  one-cycle pulse when the load completes.
REQ-015 node_count  output  ADDR_WIDTH  number of records accepted in the current load.
REQ-016 err  output  1  sticky bad-record flag (see Configuration).

Function
REQ-017 FSM states SHALL be IDLE, LOAD and DONE.
REQ-018 IDLE: in_ready=0; start=1 moves the FSM to LOAD and clears node_count to 0.
REQ-019 LOAD: in_ready=1; busy=1.
REQ-020 Handshake: a record is accepted in any cycle with in_valid && in_ready.
REQ-021 On acceptance of record k, the next cycle SHALL drive wdata=in_data and wen=1<<k for exactly one cycle; node_count then increments.
REQ-022 Latency from acceptance to wen is 1 cycle; wen and wdata are registered.
REQ-023 wdata SHALL hold its last value while wen=0.
REQ-024 Acceptance of record NUM_NODES-1 moves the FSM to DONE; in_ready=0 from the following cycle.
REQ-025 DONE lasts one cycle: done=1 in the same cycle as the final wen; the FSM then returns to IDLE.
REQ-026 start SHALL be ignored outside IDLE.
REQ-027 abort in LOAD moves the FSM to IDLE with no further wen and no done pulse.
REQ-028 abort takes priority over a same-cycle handshake: that record is discarded.
REQ-029 abort in IDLE or DONE has no effect.
REQ-030 in_valid=0 in LOAD stalls the FSM indefinitely with no timeout; node_count holds.
REQ-031 At most one wen bit is high in any cycle.
REQ-032 The node_count increment SHALL NOT wrap, because the FSM exits LOAD at NUM_NODES-1.

Reset
REQ-033 When rst_n=0 at a clock edge, the FSM SHALL enter IDLE and clear all outputs: wen=0, wdata=0, busy=0, done=0, in_ready=0, node_count=0, err=0.
REQ-034 Reset mid-load abandons the load; no wen is asserted in the cycle after reset.
REQ-035 Reset has priority over start and abort.

Configuration
REQ-036 Macro NODE_CFG_CHECK_EN defined: an accepted record with in_data[2:0] > 4 SHALL be rejected.
  - A rejected record produces no wen pulse.
  - node_count still advances.
  - err is set; it stays set until the next accepted start or reset.
REQ-037 Macro NODE_CFG_CHECK_EN undefined:
  - No index check is performed.
  - err is tied to 0.
  - Every accepted record produces a wen pulse.

Verification
REQ-038 Reset, then start with 31 back-to-back records 0x000000+k -> wen bits 0..30 pulse in consecutive cycles, each with wdata=k; done=1 with wen[30]; in_ready=0 afterwards.
REQ-039 in_valid toggling 1,0,1,0 during LOAD -> wen pulses only on the cycle after each handshake; node_count increments only on acceptance.
REQ-040 abort asserted with in_valid=1 after 10 records -> no wen[10], no done, FSM returns to IDLE; a new start reloads from node 0.
REQ-041 rst_n=0 after 5 records -> all outputs 0 on the next cycle; start pulses outside IDLE are ignored.
REQ-042 With NODE_CFG_CHECK_EN: record 3 has in_data[2:0]=3'b110 -> no wen[3], err=1 until the next start, done still pulses after 31 records.

Source files
------------

// File: rtl/node_config_loader_if.sv
// Record stream between a configuration source and node_config_loader.
//
// Handshake: a record transfers on every rising clk edge where in_valid and
// in_ready are both high. The source holds in_data stable while in_valid is
// high and not yet accepted. The loader raises in_ready only while loading.
//
// Signals:
//   in_valid - source has a record on in_data
//   in_ready - loader will accept a record this cycle
//   in_data  - node record: [21:11] median, [10:0] index ([2:0] significant)
//
// Modports: master = record source, slave = loader.
interface node_config_loader_if #(
  parameter int STORAGE_WIDTH = 22
);
  logic                     in_valid;
  logic                     in_ready;
  logic [STORAGE_WIDTH-1:0] in_data;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/node_config_loader.sv
// node_config_loader: loads NUM_NODES tree-node records, in order, into the
// per-node registers of a decision tree. Record k is broadcast on wdata with
// wen[k] pulsed one cycle after it is accepted.
//
// Optional feature: define NODE_CFG_CHECK_EN to reject records whose index
// field (in_data[2:0]) exceeds 4. A rejected record consumes a node slot
// (node_count advances) but writes nothing, and sets the sticky err flag.
// Without the macro every record is written and err is tied low.
//
// Ports:
//   clk, rst_n  - rising-edge clock, synchronous active-low reset
//   start       - one-cycle pulse, begins a load (only honoured in IDLE)
//   abort       - abandons a load in progress (only honoured in LOAD)
//   in_if       - record stream (slave side), see node_config_loader_if
//   wen         - one-hot per-node write enable, registered
//   wdata       - record broadcast to all nodes, holds while wen is 0
//   busy        - high while loading
//   done        - one-cycle pulse, coincident with the final wen
//   node_count  - records accepted in the current load
//   err         - sticky bad-record flag
//   state_dbg   - current FSM state (IDLE=0, LOAD=1, DONE=2)
module node_config_loader #(
  parameter int NUM_NODES     = 31,
  parameter int STORAGE_WIDTH = 22,
  parameter int ADDR_WIDTH    = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     abort,
  node_config_loader_if.slave      in_if,
  output logic [NUM_NODES-1:0]     wen,
  output logic [STORAGE_WIDTH-1:0] wdata,
  output logic                     busy,
  output logic                     done,
  output logic [ADDR_WIDTH-1:0]    node_count,
  output logic                     err,
  output logic [1:0]               state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;

  logic                 accept;
  logic                 last_rec;
  logic                 bad_rec;
  logic [NUM_NODES-1:0] wen_sel;

  // in_ready is only ever high in LOAD, so the handshake alone qualifies
  // acceptance; abort still wins over a same-cycle handshake below.
  assign accept   = in_if.in_valid && in_if.in_ready;
  assign last_rec = (node_count == ADDR_WIDTH'(NUM_NODES - 1));
  assign wen_sel  = NUM_NODES'(1) << node_count;

`ifdef NODE_CFG_CHECK_EN
  logic err_q;

  assign bad_rec = (in_if.in_data[2:0] > 3'd4);
  assign err     = err_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (state == IDLE && start) begin
      err_q <= 1'b0;
    end else if (state == LOAD && !abort && accept && bad_rec) begin
      err_q <= 1'b1;
    end
  end
`else
  assign bad_rec = 1'b0;
  assign err     = 1'b0;
`endif

  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      wen            <= '0;
      wdata          <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      in_if.in_ready <= 1'b0;
      node_count     <= '0;
    end else begin
      // Pulsed outputs default low every cycle.
      wen  <= '0;
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state          <= LOAD;
            node_count     <= '0;
            busy           <= 1'b1;
            in_if.in_ready <= 1'b1;
          end
        end
        LOAD: begin
          if (abort) begin
            state          <= IDLE;
            busy           <= 1'b0;
            in_if.in_ready <= 1'b0;
          end else if (accept) begin
            if (!bad_rec) begin
              wen   <= wen_sel;
              wdata <= in_if.in_data;
            end
            // Cannot wrap: LOAD is left on the last record.
            node_count <= node_count + ADDR_WIDTH'(1);
            if (last_rec) begin
              state          <= DONE;
              done           <= 1'b1;
              busy           <= 1'b0;
              in_if.in_ready <= 1'b0;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_node_config_loader.sv
module tb_node_config_loader;

  localparam int N  = 31;
  localparam int SW = 22;
  localparam int AW = 5;
`ifdef NODE_CFG_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  logic start;
  logic abort;
  always #5 clk = ~clk;

  node_config_loader_if #(.STORAGE_WIDTH(SW)) in_if ();

  logic [N-1:0]  wen;
  logic [SW-1:0] wdata;
  logic          busy;
  logic          done;
  logic [AW-1:0] node_count;
  logic          err;
  logic [1:0]    state_dbg;

  node_config_loader #(
    .NUM_NODES    (N),
    .STORAGE_WIDTH(SW),
    .ADDR_WIDTH   (AW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .in_if     (in_if),
    .wen       (wen),
    .wdata     (wdata),
    .busy      (busy),
    .done      (done),
    .node_count(node_count),
    .err       (err),
    .state_dbg (state_dbg)
  );

  // ---------------- reference model ----------------
  // Expected write event: {done, has_wen, node index, wdata}.
  logic [28:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  bit          m_load;    // loader is accepting records
  bit          m_done;    // the cycle after the final record
  int          m_cnt;     // records accepted this load
  bit          m_err;
  logic [SW-1:0] m_wdata; // last record actually written

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endfunction

  // ---------------- driver ----------------
  // One clock cycle: drive inputs after the falling edge, check the
  // registered status outputs against the model, then advance the model on
  // the rising edge using only what the bench itself drove.
  task automatic drive_cycle(input bit r, input bit s, input bit a, input bit v,
                             input logic [SW-1:0] d);
    int  k;
    bit  rej;
    bit  fin;
    bit  was_done;
    @(negedge clk);
    rst_n          = r;
    start          = s;
    abort          = a;
    in_if.in_valid = v;
    in_if.in_data  = d;
    check("status", {busy, in_if.in_ready, node_count, err, wdata},
          {m_load, m_load, AW'(m_cnt), m_err, m_wdata});
    @(posedge clk);
    if (!r) begin
      m_load  = 0;
      m_done  = 0;
      m_cnt   = 0;
      m_err   = 0;
      m_wdata = '0;
    end else begin
      was_done = m_done;
      m_done   = 0;
      if (m_load) begin
        if (a) begin
          m_load = 0;
        end else if (v) begin
          k   = m_cnt;
          m_cnt++;
          rej = CHK && (d[2:0] > 3'd4);
          if (rej) m_err = 1;
          else     m_wdata = d;
          fin = (m_cnt == N);
          if (fin) begin
            m_load = 0;
            m_done = 1;
          end
          if (!rej || fin)
            exp_q.push_back({fin, !rej, rej ? 5'd0 : 5'(k), m_wdata});
        end
      end else if (!was_done && s) begin
        m_load = 1;
        m_cnt  = 0;
        m_err  = 0;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive_cycle(1, 0, 0, 0, '0);
  endtask

  task automatic do_start();
    drive_cycle(1, 1, 0, 0, '0);
  endtask

  function automatic logic [SW-1:0] rand_rec();
    logic [SW-1:0] d;
    d      = SW'($urandom);
    d[2:0] = 3'($urandom_range(0, 4));
    return d;
  endfunction

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [28:0] obs;
    logic [28:0] exp;
    logic [4:0]  idx;
    if (rst_n !== 1'b0 || exp_q.size() != 0) begin
      check("wen_onehot", {63'd0, $onehot0(wen)}, 64'd1);
      if (wen != '0 || done) begin
        idx = '0;
        for (int i = 0; i < N; i++) if (wen[i]) idx = 5'(i);
        obs = {done, |wen, idx, wdata};
        if (exp_q.size() == 0) begin
          check("unexpected_write", {35'd0, obs}, 64'd0);
        end else begin
          exp = exp_q.pop_front();
          check("write_event", {35'd0, obs}, {35'd0, exp});
        end
      end else if (exp_q.size() != 0) begin
        exp = exp_q.pop_front();
        check("missing_write", 64'd0, {35'd0, exp});
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [SW-1:0] d;
    rst_n          = 1'b0;
    start          = 1'b0;
    abort          = 1'b0;
    in_if.in_valid = 1'b0;
    in_if.in_data  = '0;
    m_load = 0; m_done = 0; m_cnt = 0; m_err = 0; m_wdata = '0;

    // Reset, then confirm all outputs are zero.
    for (int i = 0; i < 3; i++) drive_cycle(0, 0, 0, 0, '0);
    idle(2);

    // Back-to-back load of records k.
    do_start();
    for (int k = 0; k < N; k++) drive_cycle(1, 0, 0, 1, SW'(k));
    idle(3);

    // in_valid toggling, with stray start pulses that must be ignored.
    do_start();
    for (int i = 0; i < 2 * N; i++)
      drive_cycle(1, (i % 3) == 1, 0, (i % 2) == 0, rand_rec());
    idle(3);

    // Abort with a valid record after 10 records, then reload from node 0.
    do_start();
    for (int k = 0; k < 10; k++) drive_cycle(1, 0, 0, 1, rand_rec());
    drive_cycle(1, 0, 1, 1, rand_rec());
    idle(2);
    do_start();
    for (int k = 0; k < N; k++) drive_cycle(1, 0, 0, 1, rand_rec());
    idle(2);

    // Reset after 5 records, with start and abort also asserted.
    do_start();
    for (int k = 0; k < 5; k++) drive_cycle(1, 0, 0, 1, rand_rec());
    drive_cycle(0, 1, 1, 1, rand_rec());
    idle(3);

    // Record 3 carries an out-of-range index field.
    do_start();
    for (int k = 0; k < N; k++) begin
      d = rand_rec();
      if (k == 3) d[2:0] = 3'b110;
      drive_cycle(1, 0, 0, 1, d);
    end
    idle(2);
    do_start();
    idle(1);
    drive_cycle(1, 0, 1, 0, '0);
    idle(2);

    // Randomised traffic, including full-range index fields.
    for (int i = 0; i < 600; i++) begin
      drive_cycle($urandom_range(0, 99) != 0,
                  $urandom_range(0, 7) == 0,
                  $urandom_range(0, 39) == 0,
                  $urandom_range(0, 3) != 0,
                  SW'($urandom));
    end
    idle(4);

    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
